// File: rtl/sdram_arbiter_if.sv
// Bundles the sub-controller request/command signals, the grants and the
// SDRAM command/address pins shared by the arbiter and its neighbours.
interface sdram_arbiter_if;
  // init sub-controller
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        init_end;
  // auto-refresh sub-controller
  logic        aref_req;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic        aref_end;
  logic        aref_en;
  // write sub-controller
  logic        wr_req;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_sdram_en;
  logic        wr_end;
  logic        wr_en;
  // read sub-controller
  logic        rd_req;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr;
  logic        rd_end;
  logic        rd_en;
  logic [15:0] rd_data;
  // watchdog and SDRAM pins
  logic        grant_timeout;
  logic        sdram_cke;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  // Sub-controller / pin side: drives requests and commands, receives grants.
  modport master (
    output init_cmd, init_ba, init_addr, init_end,
    output aref_req, aref_cmd, aref_addr, aref_end,
    output wr_req, wr_cmd, wr_ba, wr_addr, wr_data, wr_sdram_en, wr_end,
    output rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
    input  aref_en, wr_en, rd_en, rd_data, grant_timeout,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr
  );

  // Arbiter side.
  modport slave (
    input  init_cmd, init_ba, init_addr, init_end,
    input  aref_req, aref_cmd, aref_addr, aref_end,
    input  wr_req, wr_cmd, wr_ba, wr_addr, wr_data, wr_sdram_en, wr_end,
    input  rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
    output aref_en, wr_en, rd_en, rd_data, grant_timeout,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM bus arbiter: holds the bus for init until it completes, then grants
// it by fixed priority refresh > write > read, always passing through one
// ARBIT cycle between grants. A watchdog forces release of a hung grant.
module sdram_arbiter #(
  parameter int         TIMEOUT = 1023,
  parameter logic [3:0] NOP_CMD = 4'b0111
) (
  input  logic              clk,
  input  logic              rst,
  sdram_arbiter_if.slave    bus,
  inout  wire  [15:0]       sdram_dq
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           gto_q, gto_d;
  logic           cke_q;
  logic [15:0]    rd_data_q;

  logic           busy_s;
  logic           end_s;
  logic [3:0]     cmd_s;
  logic [1:0]     ba_s;
  logic [12:0]    addr_s;

  // State, watchdog counter and timeout pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      gto_q   <= 1'b0;
      cke_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gto_q   <= gto_d;
      cke_q   <= 1'b1;
    end
  end

  // Identify whether a grant is held and whether its owner signalled done;
  // end pulses of modules that do not own the bus are ignored here.
  always_comb begin
    busy_s = 1'b0;
    end_s  = 1'b0;
    case (state_q)
      ST_AREF:  begin busy_s = 1'b1; end_s = bus.aref_end; end
      ST_WRITE: begin busy_s = 1'b1; end_s = bus.wr_end;   end
      ST_READ:  begin busy_s = 1'b1; end_s = bus.rd_end;   end
      default:  begin busy_s = 1'b0; end_s = 1'b0;         end
    endcase
  end

  // Next-state logic: priority arbitration and watchdog release.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    gto_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (bus.init_end) state_d = ST_ARBIT;
        else              state_d = ST_INIT;
      end
      ST_ARBIT: begin
        if (bus.aref_req)    state_d = ST_AREF;
        else if (bus.wr_req) state_d = ST_WRITE;
        else if (bus.rd_req) state_d = ST_READ;
        else                 state_d = ST_ARBIT;
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        // A genuine end wins over a simultaneous expiry, so no timeout pulse.
        if (end_s) begin
          state_d = ST_ARBIT;
        end else if (busy_s && (cnt_q == TMO_C)) begin
          state_d = ST_ARBIT;
          gto_d   = 1'b1;
        end else begin
          state_d = state_q;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        // Corrupted one-hot encoding: fall back to the safe init owner.
        state_d = ST_INIT;
      end
    endcase
  end

  // Command/address mux: the bus owner is decoded straight from the state.
  always_comb begin
    cmd_s  = NOP_CMD;
    ba_s   = 2'b00;
    addr_s = 13'h0000;
    case (state_q)
      ST_INIT:  begin cmd_s = bus.init_cmd; ba_s = bus.init_ba; addr_s = bus.init_addr; end
      ST_AREF:  begin cmd_s = bus.aref_cmd; ba_s = 2'b00;       addr_s = bus.aref_addr; end
      ST_WRITE: begin cmd_s = bus.wr_cmd;   ba_s = bus.wr_ba;   addr_s = bus.wr_addr;   end
      ST_READ:  begin cmd_s = bus.rd_cmd;   ba_s = bus.rd_ba;   addr_s = bus.rd_addr;   end
      default:  begin cmd_s = NOP_CMD;      ba_s = 2'b00;       addr_s = 13'h0000;      end
    endcase
  end

  // Capture the data bus every cycle; read data needs no reset value.
  always_ff @(posedge clk) begin
    rd_data_q <= sdram_dq;
  end

  assign bus.aref_en       = (state_q == ST_AREF);
  assign bus.wr_en         = (state_q == ST_WRITE);
  assign bus.rd_en         = (state_q == ST_READ);
  assign bus.grant_timeout = gto_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.sdram_cke     = cke_q;
  assign bus.sdram_cs_n    = cmd_s[3];
  assign bus.sdram_ras_n   = cmd_s[2];
  assign bus.sdram_cas_n   = cmd_s[1];
  assign bus.sdram_we_n    = cmd_s[0];
  assign bus.sdram_ba      = ba_s;
  assign bus.sdram_addr    = addr_s;

  // Only the write owner may drive dq, and only when it asks to.
  assign sdram_dq = ((state_q == ST_WRITE) && bus.wr_sdram_en) ? bus.wr_data : {16{1'bz}};

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares the ones due in the current cycle.
module tb_sdram_arbiter;
  localparam int         TMO = 8;
  localparam logic [3:0] NOP = 4'b0111;

  localparam logic [3:0]  INIT_CMD  = 4'b0010;
  localparam logic [1:0]  INIT_BA   = 2'b01;
  localparam logic [12:0] INIT_ADDR = 13'h0400;
  localparam logic [3:0]  AREF_CMD  = 4'b0001;
  localparam logic [12:0] AREF_ADDR = 13'h0AAA;
  localparam logic [3:0]  WR_CMD    = 4'b0100;
  localparam logic [1:0]  WR_BA     = 2'b10;
  localparam logic [12:0] WR_ADDR   = 13'h0123;
  localparam logic [3:0]  RD_CMD    = 4'b0101;
  localparam logic [1:0]  RD_BA     = 2'b11;
  localparam logic [12:0] RD_ADDR   = 13'h1F00;

  localparam int S_GNT = 0;
  localparam int S_CMD = 1;
  localparam int S_GTO = 2;
  localparam int S_DQ  = 3;
  localparam int S_RDD = 4;
  localparam int S_BUS = 5;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tb_dq = 16'h0000;
  logic        tb_dq_oe = 1'b0;
  wire  [15:0] sdram_dq;

  assign sdram_dq = tb_dq_oe ? tb_dq : {16{1'bz}};

  sdram_arbiter_if bus();

  sdram_arbiter #(.TIMEOUT(TMO), .NOP_CMD(NOP)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sdram_dq (sdram_dq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_GNT:   observe = {29'd0, bus.aref_en, bus.wr_en, bus.rd_en};
      S_CMD:   observe = {27'd0, bus.sdram_cke, bus.sdram_cs_n, bus.sdram_ras_n,
                          bus.sdram_cas_n, bus.sdram_we_n};
      S_GTO:   observe = {31'd0, bus.grant_timeout};
      S_DQ:    observe = {16'd0, sdram_dq};
      S_RDD:   observe = {16'd0, bus.rd_data};
      S_BUS:   observe = {17'd0, bus.sdram_ba, bus.sdram_addr};
      default: observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic exp_at(input int c, input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_bus(input int c, input logic [2:0] g, input logic [3:0] cmd,
                         input logic [1:0] ba, input logic [12:0] addr, input string nm);
    exp_at(c, S_GNT, {29'd0, g}, {nm, "_gnt"});
    exp_at(c, S_CMD, {27'd0, 1'b1, cmd}, {nm, "_cmd"});
    exp_at(c, S_BUS, {17'd0, ba, addr}, {nm, "_ba_addr"});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = observe(sb[i].sel);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cycle %0d got %h expected %h", sb[i].name, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  // Global time bound.
  initial begin
    #20000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "time limit");
  end

  // Stimulus and direct checks.
  initial begin
    bus.init_cmd = INIT_CMD; bus.init_ba = INIT_BA; bus.init_addr = INIT_ADDR;
    bus.init_end = 1'b0;
    bus.aref_req = 1'b0; bus.aref_cmd = AREF_CMD; bus.aref_addr = AREF_ADDR;
    bus.aref_end = 1'b0;
    bus.wr_req = 1'b0; bus.wr_cmd = WR_CMD; bus.wr_ba = WR_BA; bus.wr_addr = WR_ADDR;
    bus.wr_data = 16'h0000; bus.wr_sdram_en = 1'b0; bus.wr_end = 1'b0;
    bus.rd_req = 1'b0; bus.rd_cmd = RD_CMD; bus.rd_ba = RD_BA; bus.rd_addr = RD_ADDR;
    bus.rd_end = 1'b0;
    rst = 1'b1;

    // Reset and INIT hold through cycle 10
    tick;
    while (cyc < 10) begin
      if (cyc >= 2) rst = 1'b0;
      exp_bus(cyc, 3'b000, INIT_CMD, INIT_BA, INIT_ADDR, "init");
      exp_at(cyc, S_GTO, 32'd0, "init_gto");
      tick;
    end
    bus.init_end = 1'b1;
    exp_bus(cyc, 3'b000, INIT_CMD, INIT_BA, INIT_ADDR, "init_last");
    tick; // 11
    bus.init_end = 1'b0;
    exp_bus(cyc, 3'b000, NOP, 2'b00, 13'h0000, "arbit_entry");
    checks++;
    if ({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} !== NOP) begin
      errors++;
      $display("FAIL direct_arbit_cmd cycle %0d", cyc);
    end
    tick; // 12: idle ARBIT, init_end drop ignored
    exp_bus(cyc, 3'b000, NOP, 2'b00, 13'h0000, "arbit_idle");
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;

    // Priority chain
    tick; // 13
    exp_bus(cyc, 3'b100, AREF_CMD, 2'b00, AREF_ADDR, "aref_first");
    checks++;
    if (bus.aref_en !== 1'b1) begin
      errors++;
      $display("FAIL direct_aref_en cycle %0d", cyc);
    end
    bus.aref_req = 1'b0;
    tick; // 14
    exp_bus(cyc, 3'b100, AREF_CMD, 2'b00, AREF_ADDR, "aref_hold");
    bus.aref_end = 1'b1;
    tick; // 15
    bus.aref_end = 1'b0;
    exp_bus(cyc, 3'b000, NOP, 2'b00, 13'h0000, "arbit_after_aref");
    tick; // 16
    exp_bus(cyc, 3'b010, WR_CMD, WR_BA, WR_ADDR, "write");
    checks++;
    if (bus.wr_en !== 1'b1) begin
      errors++;
      $display("FAIL direct_wr_en cycle %0d", cyc);
    end
    bus.wr_req = 1'b0;
    bus.wr_sdram_en = 1'b1; bus.wr_data = 16'hA5A5;
    exp_at(cyc, S_DQ, 32'h0000_A5A5, "wr_dq_driven");
    tick; // 17
    bus.wr_sdram_en = 1'b0;
    tb_dq = 16'h5A5A; tb_dq_oe = 1'b1;
    exp_at(cyc, S_DQ, 32'h0000_5A5A, "wr_dq_released");
    exp_bus(cyc, 3'b010, WR_CMD, WR_BA, WR_ADDR, "write_hold");
    bus.wr_end = 1'b1;
    tick; // 18
    bus.wr_end = 1'b0; tb_dq_oe = 1'b0;
    exp_bus(cyc, 3'b000, NOP, 2'b00, 13'h0000, "arbit_after_wr");
    tick; // 19
    exp_bus(cyc, 3'b001, RD_CMD, RD_BA, RD_ADDR, "read");
    checks++;
    if (bus.rd_en !== 1'b1) begin
      errors++;
      $display("FAIL direct_rd_en cycle %0d", cyc);
    end
    tb_dq = 16'h1234; tb_dq_oe = 1'b1;
    exp_at(cyc + 1, S_RDD, 32'h0000_1234, "rd_data");
    bus.wr_end = 1'b1;
    tick; // 20
    tb_dq_oe = 1'b0; bus.wr_end = 1'b0;
    exp_bus(cyc, 3'b001, RD_CMD, RD_BA, RD_ADDR, "read_ignores_wr_end");
    bus.rd_end = 1'b1; bus.rd_req = 1'b0;
    tick; // 21
    bus.rd_end = 1'b0;
    exp_bus(cyc, 3'b000, NOP, 2'b00, 13'h0000, "arbit_after_rd");
    exp_at(cyc, S_GTO, 32'd0, "rd_end_gto");
    bus.rd_req = 1'b1;

    // Watchdog expiry: read held 9 cycles (22..30), pulse in cycle 31
    tick; // 22
    bus.rd_req = 1'b0;
    for (int k = 0; k <= TMO; k++) begin
      exp_at(cyc + k, S_GNT, 32'd1, "wd_rd_en");
      exp_at(cyc + k, S_GTO, 32'd0, "wd_gto_low");
    end
    exp_bus(cyc + TMO + 1, 3'b000, NOP, 2'b00, 13'h0000, "wd_release");
    exp_at(cyc + TMO + 1, S_GTO, 32'd1, "wd_gto_pulse");
    exp_at(cyc + TMO + 2, S_GTO, 32'd0, "wd_gto_single");
    exp_at(cyc + TMO + 2, S_GNT, 32'd0, "wd_stay_arbit");
    repeat (TMO + 3) tick; // 33
    bus.rd_req = 1'b1;

    // rd_end coincident with expiry: clean release, no timeout pulse
    tick; // 34
    bus.rd_req = 1'b0;
    for (int k = 0; k <= TMO; k++) exp_at(cyc + k, S_GNT, 32'd1, "tie_rd_en");
    for (int k = 0; k <= TMO + 2; k++) exp_at(cyc + k, S_GTO, 32'd0, "tie_gto_low");
    exp_at(cyc + TMO + 1, S_GNT, 32'd0, "tie_release");
    repeat (TMO) tick; // 42
    bus.rd_end = 1'b1;
    tick; // 43
    bus.rd_end = 1'b0;
    tick; // 44
    bus.wr_req = 1'b1;

    // Reset while write drives dq
    tick; // 45
    bus.wr_req = 1'b0;
    bus.wr_sdram_en = 1'b1; bus.wr_data = 16'hC3C3;
    exp_at(cyc, S_DQ, 32'h0000_C3C3, "rst_pre_dq");
    exp_bus(cyc, 3'b010, WR_CMD, WR_BA, WR_ADDR, "rst_pre_write");
    rst = 1'b1;
    tick; // 46
    tb_dq = 16'h5A5A; tb_dq_oe = 1'b1;
    exp_at(cyc, S_DQ, 32'h0000_5A5A, "rst_dq_released");
    exp_bus(cyc, 3'b000, INIT_CMD, INIT_BA, INIT_ADDR, "rst_init");
    exp_at(cyc, S_GTO, 32'd0, "rst_gto");
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL direct_rst_wr_en cycle %0d", cyc);
    end
    rst = 1'b0;
    tick; // 47
    tb_dq_oe = 1'b0; bus.wr_sdram_en = 1'b0;
    exp_bus(cyc, 3'b000, INIT_CMD, INIT_BA, INIT_ADDR, "rst_stay_init");
    bus.init_end = 1'b1;
    tick; // 48
    bus.init_end = 1'b0;
    exp_bus(cyc, 3'b000, NOP, 2'b00, 13'h0000, "reinit_arbit");
    tick;
    tick;

    foreach (sb[i]) begin
      errors++;
      $display("FAIL %s never compared (due cycle %0d, now %0d)", sb[i].name, sb[i].cyc, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Owns the single SDRAM command, address and data bus. Multiplexes four sub-controllers onto it: init, auto-refresh, write and read.
- Sits between the init/aref/write/read modules and the SDRAM pins.
- After init completes, grants the bus by fixed priority: refresh > write > read.
- Runs a watchdog on every grant so a hung requester cannot lock the bus.

Parameters:
- TIMEOUT, 1023, max cycles a grant may be held without its *_end pulse before forced release.
- NOP_CMD, 4'b0111, {cs_n,ras_n,cas_n,we_n} driven when no module owns the bus.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous active-high reset
- init_cmd  in  4  init module command
- init_ba  in  2  init module bank address
- init_addr  in  13  init module address
- init_end  in  1  level: init finished
- aref_req  in  1  refresh request, level, held until granted
- aref_cmd  in  4  refresh module command
- aref_addr  in  13  refresh module address
- aref_end  in  1  single-cycle pulse: refresh sequence done
- aref_en  out  1  refresh grant
- wr_req  in  1  write request, level
- wr_cmd  in  4  write module command
- wr_ba  in  2  write module bank address
- wr_addr  in  13  write module address
- wr_data  in  16  write data
- wr_sdram_en  in  1  write module wants dq driven
- wr_end  in  1  pulse: write burst done
- wr_en  out  1  write grant
- rd_req  in  1  read request, level
- rd_cmd  in  4  read module command
- rd_ba  in  2  read module bank address
- rd_addr  in  13  read module address
- rd_end  in  1  pulse: read burst done
- rd_en  out  1  read grant
- rd_data  out  16  sdram_dq sampled each cycle
- grant_timeout  out  1  one-cycle pulse on watchdog release
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select, bit 3 of the command
- sdram_ras_n  out  1  bit 2 of the command
- sdram_cas_n  out  1  bit 1 of the command
- sdram_we_n  out  1  bit 0 of the command
- sdram_ba  out  2  bank address
- sdram_addr  out  13  address
- sdram_dq  inout  16  data bus

Behaviour:
- State register, one-hot. States: INIT, ARBIT, AREF, WRITE, READ.
- Reset (rst=1 at posedge):
  - state=INIT, watchdog counter=0, grant_timeout=0, sdram_cke=1.
  - aref_en/wr_en/rd_en=0.
  - Bus driven from init_* inputs; sdram_dq=Z.
- Transitions:
  - INIT: go to ARBIT the cycle after init_end is sampled 1; otherwise stay.
  - ARBIT: aref_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay. Requests sampled in the same cycle are resolved by this priority.
  - AREF/WRITE/READ: on the matching *_end=1 -> ARBIT. *_end pulses for non-active states are ignored.
  - AREF/WRITE/READ: on watchdog expiry -> ARBIT.
- Every grant passes through ARBIT for at least one cycle. There is no direct AREF->WRITE hop.
- A request pending while another grant is active waits; it is decided in the next ARBIT cycle by priority.
- Grants are a combinational decode of the state register: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ).
  - Latency: request sampled in ARBIT at cycle n -> grant high at cycle n+1.
- Bus mux (combinational from state):

| state | cmd | ba | addr |
|---|---|---|---|
| INIT | init_cmd | init_ba | init_addr |
| AREF | aref_cmd | 2'b00 | aref_addr |
| WRITE | wr_cmd | wr_ba | wr_addr |
| READ | rd_cmd | rd_ba | rd_addr |
| ARBIT | NOP_CMD | 2'b00 | 13'h0 |

- sdram_cke is constant 1 after reset.
- sdram_dq = wr_data when state==WRITE and wr_sdram_en=1; otherwise high-Z. Never driven in any other state.
- rd_data is a registered copy of sdram_dq, one cycle latency, no reset value required.
- Watchdog counter:
  - Clears in INIT/ARBIT and on entry to a grant state; increments each cycle in AREF/WRITE/READ.
  - When it reaches TIMEOUT without the matching *_end: state -> ARBIT next cycle, grant_timeout=1 for that one cycle, counter clears.
  - If *_end and expiry occur in the same cycle, the *_end release is taken and grant_timeout stays 0.
- init_end dropping after INIT is ignored; INIT is never re-entered without rst.
- rst asserted mid-grant: next cycle state=INIT, grants low, dq released.

Test Plan:
- Reset then init_end=1 at cycle 10 -> state ARBIT at cycle 11; sdram cmd equals init_cmd through cycle 10, then 4'b0111 in ARBIT.
- In ARBIT, aref_req, wr_req and rd_req all asserted together -> aref_en=1 next cycle, wr_en=rd_en=0.
  - aref_end pulse -> one ARBIT cycle, then wr_en=1.
  - After wr_end -> one ARBIT cycle, then rd_en=1.
- WRITE with wr_sdram_en=1 and wr_data=16'hA5A5 -> sdram_dq=16'hA5A5; with wr_sdram_en=0 -> Z. In READ, drive dq=16'h1234 -> rd_data=16'h1234 one cycle later.
- rd_req granted and rd_end never pulsed, TIMEOUT=8 -> rd_en high exactly 9 cycles, grant_timeout pulses once, state returns to ARBIT.
- rd_end asserted in the cycle the counter hits TIMEOUT -> release to ARBIT with grant_timeout=0.
- rst=1 while WRITE is driving dq -> next cycle wr_en=0, dq=Z, cmd=init_cmd; wr_end pulsed while in READ -> no state change.
